i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_master_if.sv | 18 +
 rtl/i2c_clk_div.sv | 32 +++
 rtl/i2c_master.sv | 153 +++++++++++++++
 tb/tb_i2c_master.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master.
//   state_t         : transaction FSM states
//   RW_WRITE/RW_READ: values of the rw request bit
//   LED_SLAVE_ADDR  : 7-bit address of the board LED slave
//   quarter_clks()  : system clocks per SCL quarter period
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] LED_SLAVE_ADDR = 7'h55;

  function automatic int quarter_clks(input int sys_hz, input int scl_hz);
    return sys_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Request/response bundle between a client and the I2C master.
//   master modport: the client (issues start with operands, sees status)
//   slave modport : the I2C master core (accepts requests, reports status)
interface i2c_master_if;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       ack_error;

  modport master (output start, rw, dev_addr, tx_data,
                  input  rx_data, busy, done, ack_error);
  modport slave  (input  start, rw, dev_addr, tx_data,
                  output rx_data, busy, done, ack_error);
endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator for the I2C bit engine.
//   clk, rst_n : system clock, async active-low reset
//   en         : count enable (the master's busy flag); counter held at 0 otherwise
//   tick       : one-cycle pulse every SYS_CLK_HZ/(4*SCL_HZ) enabled clocks
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCL_HZ     = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int Q  = quarter_clks(SYS_CLK_HZ, SCL_HZ);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  logic [CW-1:0] cnt;

  // Counter restarts from 0 whenever enabled, so the first tick lands
  // exactly Q clocks after busy rises.
  assign tick = en && (cnt == CW'(Q - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: one address byte plus one data byte per
// transaction (write or read), with ACK checking.
//   clk, rst_n : system clock, async active-low reset
//   bus        : request/status bundle (start/rw/dev_addr/tx_data in,
//                rx_data/busy/done/ack_error out)
//   scl        : push-pull I2C clock, idles high
//   sda        : open-drain I2C data, only ever pulled low
// Each bus bit spans four quarters q0..q3: scl low in q0-q1, high in q2-q3.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCL_HZ     = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  i2c_master_if.slave bus,
  output logic        scl,
  inout  wire         sda
);

  state_t     state;
  logic [1:0] q;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw_q;
  logic [7:0] tx_q;
  logic       sda_oe;
  logic       sda_meta, sda_s;
  logic       tick;

  i2c_clk_div #(.SYS_CLK_HZ(SYS_CLK_HZ), .SCL_HZ(SCL_HZ)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.busy),
    .tick (tick)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      sda_meta <= sda;
      sda_s    <= sda_meta;
    end
  end

  // All bus outputs are updated on the tick that ends a quarter, so they
  // take effect for the following quarter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      q             <= 2'd0;
      bitcnt        <= 3'd0;
      shreg         <= 8'h00;
      rw_q          <= RW_WRITE;
      tx_q          <= 8'h00;
      scl           <= 1'b1;
      sda_oe        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ack_error <= 1'b0;
      bus.rx_data   <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state         <= START;
          q             <= 2'd0;
          bitcnt        <= 3'd0;
          shreg         <= {bus.dev_addr, bus.rw};
          rw_q          <= bus.rw;
          tx_q          <= bus.tx_data;
          bus.ack_error <= 1'b0;
          bus.busy      <= 1'b1;
        end
      end else if (tick) begin
        q <= q + 2'd1;
        case (q)
          2'd0: if (state == STOP) scl <= 1'b1;
          2'd1: begin
            if (state == START)     sda_oe <= 1'b1;   // start condition
            else if (state == STOP) sda_oe <= 1'b0;   // stop condition
            else                    scl    <= 1'b1;
          end
          2'd2: begin
            case (state)
              ADDR_ACK, WR_ACK: if (sda_s) bus.ack_error <= 1'b1;
              RD_DATA:          shreg <= {shreg[6:0], sda_s};
              default: ;
            endcase
          end
          default: begin
            // q3 end: scl falls and the next bit's sda value is set up.
            if (state != STOP) scl <= 1'b0;
            case (state)
              START: begin
                state  <= ADDR;
                sda_oe <= ~shreg[7];
              end
              ADDR, WR_DATA: begin
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                  state  <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                  sda_oe <= 1'b0;
                end else begin
                  shreg  <= {shreg[6:0], 1'b0};
                  sda_oe <= ~shreg[6];
                end
              end
              ADDR_ACK: begin
                if (bus.ack_error) begin
                  state  <= STOP;
                  sda_oe <= 1'b1;
                end else if (rw_q == RW_READ) begin
                  state  <= RD_DATA;
                  sda_oe <= 1'b0;
                end else begin
                  state  <= WR_DATA;
                  shreg  <= tx_q;
                  sda_oe <= ~tx_q[7];
                end
              end
              WR_ACK: begin
                state  <= STOP;
                sda_oe <= 1'b1;
              end
              RD_DATA: begin
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) state <= RD_NACK;
              end
              RD_NACK: begin
                bus.rx_data <= shreg;
                state       <= STOP;
                sda_oe      <= 1'b1;
              end
              STOP: begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a clock-sampled bus monitor plus a behavioural
// slave (address match, ACK, read data, LED register) and directed plus
// random transactions checked against protocol-level expectations.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int SYS_HZ = 4_000_000;
  localparam int I2C_HZ = 100_000;
  localparam int Q      = SYS_HZ / (4 * I2C_HZ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  scl;
  wire  sda;
  logic slv_drv = 1'b0;

  i2c_master_if bus();

  i2c_master #(.SYS_CLK_HZ(SYS_HZ), .SCL_HZ(I2C_HZ)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .scl  (scl),
    .sda  (sda)
  );

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus monitor and slave model ----------------
  bit         bits[$];
  int         rises[$];
  int         falls[$];
  int         hi_chg = 0, stop_seen = 0, done_cnt = 0;
  logic       pscl = 1'b1, psda = 1'b1;
  logic [6:0] slave_addr = LED_SLAVE_ADDR;
  logic [7:0] slave_rdata = 8'h00;
  logic [7:0] led = 8'h00;
  logic       addr_hit = 1'b0, slv_rw = 1'b0;

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], logic'(bits[base+i])};
    return b;
  endfunction

  always @(negedge clk) begin
    int n;
    if (pscl && scl && (psda != sda)) begin
      hi_chg <= hi_chg + 1;
      if (!sda) begin
        bits.delete(); rises.delete(); falls.delete();
      end else stop_seen <= stop_seen + 1;
    end
    if (!pscl && scl) begin
      bits.push_back(sda);
      rises.push_back(cyc);
    end
    if (pscl && !scl) begin
      falls.push_back(cyc);
      n = bits.size();
      if (n == 8) begin
        addr_hit <= ((byte_at(0) >> 1) == {1'b0, slave_addr});
        slv_rw   <= bits[7];
        slv_drv  <= ((byte_at(0) >> 1) == {1'b0, slave_addr});
      end else if (n == 9) begin
        slv_drv <= addr_hit && slv_rw && !slave_rdata[7];
      end else if (n >= 10 && n <= 16) begin
        slv_drv <= addr_hit && slv_rw && !slave_rdata[3'(16 - n)];
      end else if (n == 17) begin
        slv_drv <= addr_hit && !slv_rw;
        if (addr_hit && !slv_rw) led <= byte_at(9);
      end else slv_drv <= 1'b0;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    pscl <= scl;
    psda <= sda;
  end

  // ---------------- checking ----------------
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] model_rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic rw, input logic [6:0] addr,
                        input logic [7:0] tx, input logic [6:0] sa, input logic [7:0] rd,
                        input int inject_at, input bit meas);
    bit   present = (addr == sa);
    int   exp_q   = present ? 80 : 44;
    int   cycles  = 0;
    int   d0 = done_cnt, h0 = hi_chg, s0 = stop_seen;
    logic got_done = 1'b0;
    slave_addr  = sa;
    slave_rdata = rd;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.dev_addr = addr; bus.tx_data = tx;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ":busy_after_start"}, 32'(bus.busy), 1);
    while (!got_done && cycles < exp_q * Q + 100) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == inject_at) begin
        bus.start = 1'b1; bus.rw = ~rw; bus.dev_addr = ~addr; bus.tx_data = ~tx;
      end
      if (cycles == inject_at + 1) bus.start = 1'b0;
      if (bus.done) got_done = 1'b1;
    end
    chk({tag, ":done_seen"}, 32'(got_done), 1);
    chk({tag, ":latency"}, cycles, exp_q * Q);
    chk({tag, ":busy_at_done"}, 32'(bus.busy), 0);
    chk({tag, ":ack_error"}, 32'(bus.ack_error), 32'(!present));
    if (rw && present) model_rx = rd;
    chk({tag, ":rx_data"}, 32'(bus.rx_data), 32'(model_rx));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ":done_pulses"}, done_cnt - d0, 1);
    chk({tag, ":sda_changes_scl_high"}, hi_chg - h0, 2);
    chk({tag, ":stop_cond"}, stop_seen - s0, 1);
    chk({tag, ":scl_rises"}, bits.size(), present ? 19 : 10);
    chk({tag, ":addr_byte"}, 32'(byte_at(0)), 32'({addr, rw}));
    chk({tag, ":addr_ack_bit"}, 32'(bits[8]), 32'(!present));
    if (present) begin
      chk({tag, ":data_byte"}, 32'(byte_at(9)), 32'(rw ? rd : tx));
      chk({tag, ":data_ack_bit"}, 32'(bits[17]), 32'(rw));
      if (!rw) chk({tag, ":led"}, 32'(led), 32'(tx));
    end
    if (meas) begin
      for (int k = 1; k < 18; k++) chk({tag, ":scl_period"}, rises[k] - rises[k-1], 4 * Q);
      for (int k = 0; k < 18; k++) chk({tag, ":scl_high"}, falls[k+1] - rises[k], 2 * Q);
    end
  endtask

  initial begin
    int         w;
    int         h0;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_tx, r_rd;
    bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = '0; bus.tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset:scl", 32'(scl), 1);
    chk("reset:sda", 32'(sda), 1);
    chk("reset:busy", 32'(bus.busy), 0);
    chk("reset:done", 32'(bus.done), 0);
    chk("reset:ack_error", 32'(bus.ack_error), 0);
    chk("reset:rx_data", 32'(bus.rx_data), 0);

    // Test 1 and 6: LED write with SCL timing measured
    do_txn("t1_led_write", RW_WRITE, LED_SLAVE_ADDR, 8'hA5, LED_SLAVE_ADDR, 8'h00, 0, 1'b1);
    // Test 2: address NACK
    do_txn("t2_addr_nack", RW_WRITE, 7'h20, 8'h5A, LED_SLAVE_ADDR, 8'h00, 0, 1'b0);
    // Test 3: read 0xC3 from 0x3C
    do_txn("t3_read", RW_READ, 7'h3C, 8'h00, 7'h3C, 8'hC3, 0, 1'b0);
    // Test 4: start mid-transaction is ignored
    do_txn("t4_start_busy", RW_WRITE, 7'h12, 8'h81, 7'h12, 8'h00, 30 * Q, 1'b0);

    // Test 5: reset during ADDR bit 3 (0xAA bit 3 drives sda low)
    h0 = hi_chg;
    slave_addr = LED_SLAVE_ADDR;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = RW_WRITE; bus.dev_addr = LED_SLAVE_ADDR; bus.tx_data = 8'h3C;
    @(posedge clk); #1;
    bus.start = 1'b0;
    w = 0;
    while (hi_chg == h0 && w < 20 * Q) begin @(posedge clk); w++; end
    w = 0;
    while (rises.size() < 3 && w < 40 * Q) begin @(posedge clk); w++; end
    chk("t5:reached_bit3", 32'(rises.size() >= 3), 1);
    repeat (3 * Q) @(posedge clk);
    #3;
    chk("t5:sda_low_before_reset", 32'(sda), 0);
    rst_n = 1'b0;
    #1;
    chk("t5:scl_in_reset", 32'(scl), 1);
    chk("t5:sda_in_reset", 32'(sda), 1);
    chk("t5:busy_in_reset", 32'(bus.busy), 0);
    chk("t5:done_in_reset", 32'(bus.done), 0);
    chk("t5:rx_in_reset", 32'(bus.rx_data), 0);
    model_rx = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_txn("t5_after_reset", RW_WRITE, LED_SLAVE_ADDR, 8'h3C, LED_SLAVE_ADDR, 8'h00, 0, 1'b0);

    // Random transactions: address hit or miss, read or write
    for (int i = 0; i < 6; i++) begin
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom_range(0, 127));
      r_tx   = 8'($urandom_range(0, 255));
      r_rd   = 8'($urandom_range(0, 255));
      do_txn("rand", r_rw, r_addr, r_tx,
             ($urandom_range(0, 2) != 0) ? r_addr : (r_addr ^ 7'h41), r_rd, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
